clock_display_scan: RTL and testbench

- Reader side of the time counters: consumes the binary `cnt_s`, `cnt_mi` and `cnt_h` values and drives a 6-digit multiplexed 7-segment display (HH MM SS).
- Snapshots all three counters once per display frame and converts each to two BCD digits with a sequential subtract-by-10 engine.
- Scans the six digits round-robin at a parameterised rate.
- Sits beside the counter chain at top level, fed directly by the counter outputs.

---
 rtl/clock_display_scan.sv | 171 +++++++++++++++++
 tb/tb_clock_display_scan.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Snapshots cnt_s/cnt_mi/cnt_h once per display frame, converts them to BCD by repeated
// subtract-by-10 and scans six 7-segment digits. Define CLOCK_DISPLAY_DP_BLINK_EN for blinking colon dots.
module clock_display_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_1s,
  input  logic [5:0] cnt_s,
  input  logic [5:0] cnt_mi,
  input  logic [5:0] cnt_h,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_valid
);

  localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CONV   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  logic [CW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            init_q;
  state_t          state_q;
  logic [2:0][5:0] rem_q;
  logic [2:0][2:0] tens_q;
  logic [5:0][3:0] disp_q;
  logic [6:0]      seg_q;
  logic            dp_q;
  logic [5:0]      an_q;
  logic            frame_valid_q;
  logic            tick_s, start_req_s, conv_done_s, dp_raw_s;
  logic [2:0]      ge10_s;
  logic [3:0]      digit_s;

  // Segment pattern, bit 0 = a ... bit 6 = g, active-high; unreachable codes blank
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    tick_s     = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = tick_s ? '0 : scan_cnt_q + CW'(1);
    if (tick_s) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
    start_req_s = init_q | (tick_s & (idx_q == 3'd5));
    for (int i = 0; i < 3; i++) begin
      ge10_s[i] = (rem_q[i] >= 6'd10);
    end
    conv_done_s = ~|ge10_s;
    // Outputs follow the index that becomes current at this edge
    case (idx_d)
      3'd0:    digit_s = disp_q[0];
      3'd1:    digit_s = disp_q[1];
      3'd2:    digit_s = disp_q[2];
      3'd3:    digit_s = disp_q[3];
      3'd4:    digit_s = disp_q[4];
      3'd5:    digit_s = disp_q[5];
      default: digit_s = 4'hF;
    endcase
  end

`ifdef CLOCK_DISPLAY_DP_BLINK_EN
  logic blink_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= 1'b0;
    end else if (pulse_1s) begin
      blink_q <= ~blink_q;
    end else begin
      blink_q <= blink_q;
    end
  end

  assign dp_raw_s = blink_q & ((idx_d == 3'd2) | (idx_d == 3'd4));
`else
  logic unused_pulse_s;
  assign unused_pulse_s = pulse_1s;
  assign dp_raw_s       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
      init_q     <= 1'b1;
      seg_q      <= {7{SEG_ACTIVE_LOW}};
      dp_q       <= SEG_ACTIVE_LOW;
      an_q       <= {6{AN_ACTIVE_LOW}};
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      init_q     <= 1'b0;
      seg_q      <= seg_decode(digit_s) ^ {7{SEG_ACTIVE_LOW}};
      dp_q       <= dp_raw_s ^ SEG_ACTIVE_LOW;
      an_q       <= (6'd1 << idx_d) ^ {6{AN_ACTIVE_LOW}};
    end
  end

  // Digits are final in the last CONV cycle, so they land in disp_q together with frame_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      tens_q        <= '0;
      disp_q        <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_req_s) state_q <= LOAD;
        end
        LOAD: begin
          rem_q   <= {cnt_h, cnt_mi, cnt_s};
          tens_q  <= '0;
          state_q <= CONV;
        end
        CONV: begin
          if (conv_done_s) begin
            disp_q <= {1'b0, tens_q[2], rem_q[2][3:0],
                       1'b0, tens_q[1], rem_q[1][3:0],
                       1'b0, tens_q[0], rem_q[0][3:0]};
            frame_valid_q <= 1'b1;
            state_q       <= COMMIT;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (ge10_s[i]) begin
                rem_q[i]  <= rem_q[i] - 6'd10;
                tens_q[i] <= tens_q[i] + 3'd1;
              end
            end
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: frame-level reference model compared every cycle, plus
// directed literal checks for reset, latency, conversion, overflow, tearing, reset abort and dp.
module tb_clock_display_scan;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_1s = 1'b0;
  logic [5:0] cnt_s = 6'd0, cnt_mi = 6'd0, cnt_h = 6'd0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_valid;

  clock_display_scan #(.SCAN_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .pulse_1s(pulse_1s),
    .cnt_s(cnt_s), .cnt_mi(cnt_mi), .cnt_h(cnt_h),
    .seg(seg), .dp(dp), .an(an), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;
  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] segx(input int d);
    return ~seg_tab[d];
  endfunction

  // ---------------- reference model (frame level) ----------------
  int   m_cnt, m_idx, m_phase, m_count;
  bit   m_init, m_blink;
  int   m_disp [6];
  int   m_next [6];
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_fv;

  always @(posedge clk) begin : model
    int v [3];
    int new_idx, mx;
    bit tick, start;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_phase = 0; m_count = 0;
      m_init = 1'b1; m_blink = 1'b0;
      for (int i = 0; i < 6; i++) m_disp[i] = 0;
      exp_an = 6'h3F; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fv = 1'b0;
    end else begin
      tick    = (m_cnt == DIV - 1);
      start   = m_init || (tick && m_idx == 5);
      m_init  = 1'b0;
      new_idx = tick ? (m_idx + 1) % 6 : m_idx;
      exp_an  = 6'h3F ^ (6'd1 << new_idx);
      exp_seg = ~seg_tab[m_disp[new_idx]];
      exp_dp  = !(m_blink && (new_idx == 2 || new_idx == 4));
      exp_fv  = 1'b0;
      case (m_phase)
        0: if (start) m_phase = 1;
        1: begin
          v[0] = cnt_s; v[1] = cnt_mi; v[2] = cnt_h;
          mx = 0;
          for (int f = 0; f < 3; f++) begin
            m_next[2*f]   = v[f] % 10;
            m_next[2*f+1] = v[f] / 10;
            if (v[f] / 10 > mx) mx = v[f] / 10;
          end
          m_count = mx + 1;
          m_phase = 2;
        end
        2: begin
          m_count--;
          if (m_count == 0) begin
            for (int i = 0; i < 6; i++) m_disp[i] = m_next[i];
            exp_fv  = 1'b1;
            m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
`ifdef CLOCK_DISPLAY_DP_BLINK_EN
      if (pulse_1s) m_blink = !m_blink;
`endif
      m_cnt = (m_cnt + 1) % DIV;
      m_idx = new_idx;
    end
  end

  // Single compare process against the model, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("an", an, exp_an);
      chk("seg", seg, exp_seg);
      chk("dp", dp, exp_dp);
      chk("frame_valid", frame_valid, exp_fv);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_fv(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (frame_valid) got = 1'b1;
    end
    if (!got) chk(name, 32'(got), 32'd1);
  endtask

  task automatic wait_idx(input int i, input string name);
    bit got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (an == (6'h3F ^ (6'd1 << i))) got = 1'b1;
    end
    if (!got) chk(name, 32'(got), 32'd1);
  endtask

  task automatic measure_latency(output int lat);
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (frame_valid) lat = k;
    end
  endtask

  task automatic scan_record(output logic [6:0] seen [6]);
    for (int i = 0; i < 6; i++) seen[i] = 7'bx;
    for (int k = 0; k < 6 * DIV + 2; k++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++)
        if (an == (6'h3F ^ (6'd1 << i))) seen[i] = seg;
    end
  endtask

  task automatic check_digits(input string name, input logic [6:0] seen [6], input int d [6]);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_an%0d", name, i), seen[i], segx(d[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, fv_cnt;
    logic [6:0] seen [6];
    int exp_d [6];
    logic exp_lit;

    rst = 1'b1; cnt_s = 6'd63; cnt_mi = 6'd63; cnt_h = 6'd63;
    @(posedge clk);
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an, 6'h3F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fv", frame_valid, 1'b0);

    rst = 1'b0;
    measure_latency(lat);
    chk("latency_63", lat, 9);

    rst = 1'b1; cnt_s = 6'd0; cnt_mi = 6'd0; cnt_h = 6'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure_latency(lat);
    chk("latency_0", lat, 3);

    // 23:59:07
    cnt_h = 6'd23; cnt_mi = 6'd59; cnt_s = 6'd7;
    wait_fv("fv_conv_a"); wait_fv("fv_conv_b");
    scan_record(seen);
    exp_d = '{7, 0, 9, 5, 3, 2};
    check_digits("conv", seen, exp_d);
    chk("seg_nine", seen[2], 7'h10);

    // Overflow value 63 in seconds
    cnt_h = 6'd12; cnt_mi = 6'd0; cnt_s = 6'd63;
    wait_fv("fv_ovf_a"); wait_fv("fv_ovf_b");
    scan_record(seen);
    exp_d = '{3, 6, 0, 0, 2, 1};
    check_digits("ovf", seen, exp_d);

    // Tearing: input change mid-frame stays hidden until the next commit
    cnt_h = 6'd5; cnt_mi = 6'd34; cnt_s = 6'd12;
    wait_fv("fv_tear_a"); wait_fv("fv_tear_b");
    for (int i = 0; i < 2; i++) seen[i] = 7'bx;
    for (int k = 0; k < 200 && an != 6'h3B; k++) begin
      @(negedge clk);
      if (an == 6'h3E) seen[0] = seg;
      if (an == 6'h3D) seen[1] = seg;
    end
    chk("tear_old_u", seen[0], 7'h24);
    chk("tear_old_t", seen[1], 7'h79);
    cnt_s = 6'd45;
    wait_fv("fv_tear_c");
    scan_record(seen);
    chk("tear_new_u", seen[0], 7'h12);
    chk("tear_new_t", seen[1], 7'h19);

    // Randomized run, including pulses and occasional resets
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        cnt_s  = 6'($urandom_range(0, 63));
        cnt_mi = 6'($urandom_range(0, 63));
        cnt_h  = 6'($urandom_range(0, 63));
      end
      pulse_1s = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    pulse_1s = 1'b0; rst = 1'b0;

    // Reset two cycles into CONV aborts the frame
    rst = 1'b1; cnt_s = 6'd63; cnt_mi = 6'd63; cnt_h = 6'd63;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fv_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frame_valid) fv_cnt++;
    end
    chk("abort_fv_count", fv_cnt, 0);
    chk("abort_an", an, 6'h3F);
    chk("abort_seg", seg, 7'h7F);
    chk("abort_dp", dp, 1'b1);
    rst = 1'b0;

    // Colon dots
`ifdef CLOCK_DISPLAY_DP_BLINK_EN
    exp_lit = 1'b0;
`else
    exp_lit = 1'b1;
`endif
    repeat (4) @(negedge clk);
    pulse_1s = 1'b1;
    @(negedge clk);
    pulse_1s = 1'b0;
    wait_idx(2, "dp_wait2");
    chk("dp_an2_first", dp, exp_lit);
    wait_idx(3, "dp_wait3");
    chk("dp_an3_first", dp, 1'b1);
    wait_idx(4, "dp_wait4");
    chk("dp_an4_first", dp, exp_lit);
    pulse_1s = 1'b1;
    @(negedge clk);
    pulse_1s = 1'b0;
    wait_idx(2, "dp_wait2b");
    chk("dp_an2_second", dp, 1'b1);
    wait_idx(4, "dp_wait4b");
    chk("dp_an4_second", dp, 1'b1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
